// File: rtl/btn_event_arbiter_pkg.sv
// Shared definitions for the button event arbiter.
// Contents:
//   arb_state_t         arbiter state encoding (IDLE / GRANT / STALL)
//   DEFAULT_NUM_BTN     default number of button pulse inputs
//   DEFAULT_FIFO_DEPTH  default event queue depth
//   BTN_UP..BTN_RIGHT   button index constants as seen on o_event_id
package btn_event_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    STALL = 2'd2
  } arb_state_t;

  localparam int DEFAULT_NUM_BTN    = 4;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

endpackage

// File: rtl/btn_event_arbiter_event_fifo.sv
// event_fifo: synchronous valid/ready queue of button indices.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_push, i_data  write request and data (ignored when full unless popping)
//   o_valid, o_data queue head; o_data reads 0 while empty
//   i_ready         consumer accepts the head (pop when o_valid && i_ready)
//   o_count         number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module event_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop;
  logic             do_push;

  assign pop     = o_valid && i_ready;
  // A full queue still takes a write when the head leaves in the same cycle.
  assign do_push = i_push && ((count != CW'(DEPTH)) || pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_valid = (count != '0);
  // Storage is not reset, so mask the head while empty.
  assign o_data  = o_valid ? mem[rd_ptr] : '0;
  assign o_count = count;

endmodule

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: collects one-cycle release pulses from the button
// debouncers into per-button pending flags, grants one pending button per
// cycle into an event queue, and presents the queue head to the mode FSM.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_button         release pulses, one bit per button
//   o_event_valid    queue head holds an event
//   o_event_id       button index of the queue head (0 when empty)
//   i_event_ready    consumer accepts the head
//   o_pending        per-button pending flags
//   o_drop           one-cycle pulse when a pulse is lost
// Configuration: define BTN_ARB_RR_EN for round-robin arbitration; without it
// the lowest pending index always wins.
module btn_event_arbiter
  import btn_event_arbiter_pkg::*;
#(
  parameter int NUM_BTN    = DEFAULT_NUM_BTN,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_BTN-1:0]         i_button,
  output logic                       o_event_valid,
  output logic [$clog2(NUM_BTN)-1:0] o_event_id,
  input  logic                       i_event_ready,
  output logic [NUM_BTN-1:0]         o_pending,
  output logic                       o_drop
);

  localparam int IDW = $clog2(NUM_BTN);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  arb_state_t         state;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] pending_nxt;
  logic [NUM_BTN-1:0] grant_vec;
  logic [NUM_BTN-1:0] drop_vec;
  logic [IDW-1:0]     grant_idx;
  logic               found;
  logic               can_push;
  logic               push;
  logic               pop;
  logic               drop_q;
  logic               full_nxt;
  logic [CW-1:0]      fifo_count;
  logic [CW:0]        count_nxt;
`ifdef BTN_ARB_RR_EN
  logic [IDW-1:0]     rr_ptr;
`endif

  assign pop = o_event_valid && i_event_ready;
  // GRANT means the queue had room at the start of the cycle; STALL means it
  // was full, so a push is only possible when the head is popped alongside.
  assign can_push = (state == GRANT) || ((state == STALL) && pop);

  always_comb begin : arbiter
    found     = 1'b0;
    grant_idx = '0;
`ifdef BTN_ARB_RR_EN
    begin : rr_search
      int            cand;
      logic [IDW-1:0] cand_idx;
      cand     = 0;
      cand_idx = '0;
      for (int i = 1; i <= NUM_BTN; i++) begin
        cand = int'(rr_ptr) + i;
        if (cand >= NUM_BTN) cand = cand - NUM_BTN;
        cand_idx = IDW'(cand);
        if (!found && pending[cand_idx]) begin
          found     = 1'b1;
          grant_idx = cand_idx;
        end
      end
    end
`else
    for (int i = 0; i < NUM_BTN; i++) begin
      if (!found && pending[IDW'(i)]) begin
        found     = 1'b1;
        grant_idx = IDW'(i);
      end
    end
`endif
    push      = found && can_push;
    grant_vec = '0;
    if (push) grant_vec[grant_idx] = 1'b1;
  end

  // A pulse re-arms its flag even in the cycle the old event is granted; it
  // is only lost when the flag is still occupied after this cycle's grant.
  always_comb begin : next_state
    pending_nxt = (pending & ~grant_vec) | i_button;
    drop_vec    = pending & ~grant_vec & i_button;
    count_nxt   = {1'b0, fifo_count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    full_nxt    = (count_nxt == (CW+1)'(FIFO_DEPTH));
  end

  // State reflects the coming cycle: IDLE with nothing pending, STALL when
  // work waits on a full queue, GRANT otherwise.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      pending <= '0;
      drop_q  <= 1'b0;
`ifdef BTN_ARB_RR_EN
      rr_ptr  <= IDW'(NUM_BTN - 1);
`endif
    end else begin
      pending <= pending_nxt;
      drop_q  <= |drop_vec;
      if (pending_nxt == '0) state <= IDLE;
      else if (full_nxt)     state <= STALL;
      else                   state <= GRANT;
`ifdef BTN_ARB_RR_EN
      if (push) rr_ptr <= grant_idx;
`endif
    end
  end

  event_fifo #(
    .WIDTH (IDW),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_data  (grant_idx),
    .i_ready (i_event_ready),
    .o_valid (o_event_valid),
    .o_data  (o_event_id),
    .o_count (fifo_count)
  );

  assign o_pending = pending;
  assign o_drop    = drop_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed self-checking bench for btn_event_arbiter (NUM_BTN=4, FIFO_DEPTH=4).
// Expected values are hand-computed; round-robin specific expectations are
// selected with BTN_ARB_RR_EN to match the design build.
module tb_btn_event_arbiter;
  import btn_event_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = '0;
  logic       rdy = 1'b0;
  logic       valid;
  logic [1:0] id;
  logic [3:0] pend;
  logic       drop;

  int assertCount = 0;
  int failCount   = 0;

  btn_event_arbiter #(
    .NUM_BTN    (4),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_button      (btn),
    .o_event_valid (valid),
    .o_event_id    (id),
    .i_event_ready (rdy),
    .o_pending     (pend),
    .o_drop        (drop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic expectState(input string tag, input int v, input int idv, input int p, input int d);
    checkOutput({tag, ".valid"},   int'(valid), v);
    checkOutput({tag, ".id"},      int'(id),    idv);
    checkOutput({tag, ".pending"}, int'(pend),  p);
    checkOutput({tag, ".drop"},    int'(drop),  d);
  endtask

  // Present one cycle of button pulses and ready, then sample after the edge.
  task automatic applyStimulus(input logic [3:0] b, input logic r);
    btn = b;
    rdy = r;
    @(posedge clk);
    #1;
    btn = '0;
  endtask

  // Reset with pulses and ready active to show they are ignored.
  task automatic applyReset();
    rst = 1'b1;
    btn = 4'b1111;
    rdy = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    btn = '0;
    rdy = 1'b0;
  endtask

  initial begin
    applyReset();
    expectState("reset", 0, 0, 0, 0);

    // Single pulse on LEFT: pending after one edge, event after two.
    applyStimulus(4'b0100, 1'b1);
    expectState("single.p", 0, 0, 4, 0);
    applyStimulus(4'b0000, 1'b1);
    expectState("single.ev", 1, BTN_LEFT, 0, 0);
    applyStimulus(4'b0000, 1'b1);
    expectState("single.done", 0, 0, 0, 0);

    // All four buttons at once, twice: both arbiters produce 0,1,2,3.
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(4'b1111, 1'b1);
      expectState("all.p", 0, 0, 15, 0);
      for (int k = 0; k < 4; k++) begin
        applyStimulus(4'b0000, 1'b1);
        expectState($sformatf("all.ev%0d", k), 1, k, 15 & ~((2 << k) - 1), 0);
      end
      applyStimulus(4'b0000, 1'b1);
      expectState("all.empty", 0, 0, 0, 0);
    end

    // Consumer stalled: fill the queue, then hold a pending UP against it.
    applyStimulus(4'b1111, 1'b0);
    expectState("fill.p", 0, 0, 15, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0000, 1'b0);
      expectState($sformatf("fill.q%0d", k), 1, 0, 15 & ~((2 << k) - 1), 0);
    end
    applyStimulus(4'b0001, 1'b0);
    expectState("full.pend", 1, 0, 1, 0);
    applyStimulus(4'b0000, 1'b0);
    expectState("full.hold", 1, 0, 1, 0);
    applyStimulus(4'b0001, 1'b0);
    expectState("full.drop", 1, 0, 1, 1);
    applyStimulus(4'b0010, 1'b0);
    expectState("full.p1", 1, 0, 3, 0);

    // Pop while full: each cycle pops and pushes, queue stays full.
    applyStimulus(4'b0000, 1'b1);
    expectState("swap0", 1, 1, 2, 0);
    applyStimulus(4'b0000, 1'b1);
    expectState("swap1", 1, 2, 0, 0);
    applyStimulus(4'b0000, 1'b1);
    expectState("drain0", 1, 3, 0, 0);
    applyStimulus(4'b0000, 1'b1);
    expectState("drain1", 1, 0, 0, 0);
    applyStimulus(4'b0000, 1'b1);
    expectState("drain2", 1, 1, 0, 0);
    applyStimulus(4'b0000, 1'b1);
    expectState("drain3", 0, 0, 0, 0);

    // Continuous pulses on UP and DOWN with the consumer always ready.
    applyStimulus(4'b0011, 1'b1);
    expectState("cont0", 0, 0, 3, 0);
    for (int i = 1; i < 6; i++) begin
      applyStimulus(4'b0011, 1'b1);
`ifdef BTN_ARB_RR_EN
      expectState($sformatf("cont%0d", i), 1, (i - 1) % 2, 3, 1);
`else
      expectState($sformatf("cont%0d", i), 1, BTN_UP, 3, 1);
`endif
    end
    applyReset();
    expectState("reset2", 0, 0, 0, 0);

    // Three events queued and DOWN pending, then reset discards everything.
    applyStimulus(4'b1101, 1'b0);
    expectState("pre.p", 0, 0, 13, 0);
    applyStimulus(4'b0000, 1'b0);
    expectState("pre.q0", 1, 0, 12, 0);
    applyStimulus(4'b0000, 1'b0);
    expectState("pre.q1", 1, 0, 8, 0);
    applyStimulus(4'b0010, 1'b0);
    expectState("pre.q2", 1, 0, 2, 0);
    applyReset();
    expectState("reset3", 0, 0, 0, 0);
    applyStimulus(4'b1000, 1'b1);
    expectState("post.p", 0, 0, 8, 0);
    applyStimulus(4'b0000, 1'b1);
    expectState("post.ev", 1, BTN_RIGHT, 0, 0);
    applyStimulus(4'b0000, 1'b1);
    expectState("post.done", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/btn_event_arbiter.md
BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_BTN, default 4, meaning the number of debounced button pulse inputs (2..8).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the event queue depth (power of two, 2..16).
REQ-003 The block SHALL have port i_clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port i_button, input, NUM_BTN bits, one-cycle release pulses from the per-button debouncers.
REQ-006 The block SHALL have port o_event_valid, output, 1 bit, meaning the queue head holds an event.
REQ-007 The block SHALL have port o_event_id, output, clog2(NUM_BTN) bits, the button index of the queue head.
REQ-008 The block SHALL have port i_event_ready, input, 1 bit, the consumer (mode FSM) accepting the head.
REQ-009 The block SHALL have port o_pending, output, NUM_BTN bits, the per-button pending flags.
REQ-010 The block SHALL have port o_drop, output, 1 bit, a one-cycle pulse when a pulse is lost.

Function
REQ-011 A pulse on i_button[k] SHALL set pending[k] at the next edge.
REQ-012 Each cycle, if any pending bit is set and the queue can accept, the arbiter SHALL grant exactly one index, push it and clear that pending bit.
REQ-013 The queue SHALL accept a push when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs in the same cycle.
REQ-014 A pop SHALL occur when o_event_valid && i_event_ready; o_event_id SHALL remain stable while valid and not ready.
REQ-015 Latency SHALL be 2 cycles with an idle empty queue: pulse at edge N, pending at N+1, o_event_valid high after N+2.
REQ-016 A pulse on i_button[k] while pending[k] is set and not granted that cycle SHALL leave pending[k] set and pulse o_drop.
REQ-017 A pulse on i_button[k] in the same cycle pending[k] is granted SHALL leave pending[k] set (new event kept), with no o_drop.
REQ-018 Pulses on several buttons in one cycle SHALL all set their pending bits without drop.
REQ-019 When the queue is full and no pop occurs, pending bits SHALL be held and no grant made.
REQ-020 The queue count SHALL never exceed FIFO_DEPTH; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 The arbiter state machine SHALL have states IDLE (no pending), GRANT (pending and queue can accept), STALL (pending and queue full); IDLE->GRANT on any pending, GRANT->STALL when full without pop, STALL->GRANT on pop, any->IDLE when pending is all zero.

Reset
REQ-022 On i_reset SHALL clear pending, the queue count and pointers, and the round-robin pointer, and drive o_event_valid=0, o_event_id=0, o_pending=0, o_drop=0 at the next edge.
REQ-023 Pulses and i_event_ready coincident with i_reset SHALL be ignored; queued events are discarded.

Configuration
REQ-024 With macro BTN_ARB_RR_EN defined, the arbiter SHALL be round-robin, searching from last granted index +1 with wrap; reset pointer = NUM_BTN-1, so index 0 wins first.
REQ-025 Without BTN_ARB_RR_EN, the arbiter SHALL be fixed priority, lowest index wins.

Structure
REQ-026 A shared package SHALL hold the arbiter state enumeration (IDLE/GRANT/STALL), the default NUM_BTN and FIFO_DEPTH, and the button index constants (BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3).
REQ-027 The queue SHALL be a sub-module named event_fifo (synchronous, valid/ready, same-cycle push and pop when full).

Verification
REQ-028 Pulse i_button=4'b0100 once, ready=1 -> o_event_valid high 2 cycles later with o_event_id=2 for one cycle; o_drop stays 0.
REQ-029 Pulse 4'b1111 once, ready=1 -> ids 0,1,2,3 in order (RR and fixed); second identical pulse with RR -> 0,1,2,3 again.
REQ-030 Hold ready=0, pulse 4'b1111 then 4'b0001 -> four events queued, the second pulse on button 0 granted only after a pop; no drop; then a third pulse on button 0 while pending -> o_drop one cycle.
REQ-031 Full queue, ready=1 one cycle with pending[1] set -> pop and push in the same cycle, count stays 4, o_event_id advances.
REQ-032 Continuous pulses on buttons 0 and 1, ready=1: BTN_ARB_RR_EN defined -> ids alternate 0,1,0,1; undefined -> button 1 dropped repeatedly with o_drop pulses.
REQ-033 Assert i_reset with 3 events queued and pending=4'b0010 -> next cycle o_event_valid=0, o_pending=0, and the first post-reset pulse on button 3 yields id 3 after 2 cycles.
